// File: rtl/register_file_if.sv
// Operand/write-back bus between the ALU/sequencer (master) and the register bank (slave).
interface register_file_if;
  logic [3:0]  rd_sel_A;
  logic [3:0]  rd_sel_B;
  logic [7:0]  rd_A;
  logic [7:0]  rd_B;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        flags_we;
  logic [3:0]  next_flags;
  logic [3:0]  curr_flags;
  logic        addr_we;
  logic [2:0]  addr_sel;
  logic [15:0] addr_data;
  logic        PC_inc_h;
  logic        PC_dec_h;
  logic        SP_inc_h;
  logic        SP_dec_h;
  logic        pc_inc;
  logic [15:0] pc;
  logic [15:0] sp;
  logic [15:0] hl;
  logic [15:0] wz;
  logic        fix_pending;

  modport master (
    output rd_sel_A, rd_sel_B, wr_en, wr_sel, wr_data, flags_we, next_flags,
           addr_we, addr_sel, addr_data, PC_inc_h, PC_dec_h, SP_inc_h, SP_dec_h, pc_inc,
    input  rd_A, rd_B, curr_flags, pc, sp, hl, wz, fix_pending
  );

  modport slave (
    input  rd_sel_A, rd_sel_B, wr_en, wr_sel, wr_data, flags_we, next_flags,
           addr_we, addr_sel, addr_data, PC_inc_h, PC_dec_h, SP_inc_h, SP_dec_h, pc_inc,
    output rd_A, rd_B, curr_flags, pc, sp, hl, wz, fix_pending
  );
endinterface

// File: rtl/register_file.sv
// CPU register bank: operand reads, ALU write-back, and the deferred PC/SP high-byte
// fixup that completes a signed low-byte add one cycle later.
module register_file (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave rf
);
  typedef enum logic [1:0] {FIX_NONE, FIX_INC, FIX_DEC} fix_e;

  localparam logic [3:0] R_B = 4'd0, R_C = 4'd1, R_D = 4'd2, R_E = 4'd3, R_H = 4'd4,
                         R_L = 4'd5, R_F = 4'd6, R_A = 4'd7, R_SPH = 4'd8, R_SPL = 4'd9,
                         R_PCH = 4'd10, R_PCL = 4'd11, R_W = 4'd12, R_Z = 4'd13;
  localparam logic [2:0] P_BC = 3'd0, P_DE = 3'd1, P_HL = 3'd2, P_SP = 3'd3, P_PC = 3'd4,
                         P_WZ = 3'd5;

  logic [7:0]  a_q, b_q, c_q, d_q, e_q, h_q, l_q, w_q, z_q;
  logic [7:0]  a_d, b_d, c_d, d_d, e_d, h_d, l_d, w_d, z_d;
  logic [3:0]  f_q, f_d;
  logic [15:0] sp_q, sp_d, pc_q, pc_d;
  fix_e        pc_fix_q, pc_fix_d, sp_fix_q, sp_fix_d;
  logic [7:0]  rd_view [16];
  logic        pc_explicit;

  function automatic fix_e fix_of(input logic inc, input logic dec);
    if (inc && !dec)      return FIX_INC;
    else if (dec && !inc) return FIX_DEC;
    else                  return FIX_NONE;
  endfunction

  function automatic logic [7:0] adj_hi(input logic [7:0] hi, input fix_e fix);
    case (fix)
      FIX_INC: return hi + 8'd1;
      FIX_DEC: return hi - 8'd1;
      default: return hi;
    endcase
  endfunction

  assign pc_explicit = (rf.wr_en && (rf.wr_sel == R_PCH || rf.wr_sel == R_PCL)) ||
                       (rf.addr_we && rf.addr_sel == P_PC);

  // Lowest priority is applied first so later assignments override it.
  always_comb begin
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; e_d = e_q;
    h_d = h_q; l_d = l_q; w_d = w_q; z_d = z_q; f_d = f_q;
    pc_d = {adj_hi(pc_q[15:8], pc_fix_q), pc_q[7:0]};
    sp_d = {adj_hi(sp_q[15:8], sp_fix_q), sp_q[7:0]};
    if (rf.pc_inc && !pc_explicit) pc_d = pc_d + 16'd1;
    if (rf.wr_en) begin
      case (rf.wr_sel)
        R_B:     b_d = rf.wr_data;
        R_C:     c_d = rf.wr_data;
        R_D:     d_d = rf.wr_data;
        R_E:     e_d = rf.wr_data;
        R_H:     h_d = rf.wr_data;
        R_L:     l_d = rf.wr_data;
        R_F:     f_d = rf.wr_data[7:4];
        R_A:     a_d = rf.wr_data;
        R_SPH:   sp_d[15:8] = rf.wr_data;
        R_SPL:   sp_d[7:0]  = rf.wr_data;
        R_PCH:   pc_d[15:8] = rf.wr_data;
        R_PCL:   pc_d[7:0]  = rf.wr_data;
        R_W:     w_d = rf.wr_data;
        R_Z:     z_d = rf.wr_data;
        default: ;
      endcase
    end
    if (rf.flags_we) f_d = rf.next_flags;
    if (rf.addr_we) begin
      case (rf.addr_sel)
        P_BC:    {b_d, c_d} = rf.addr_data;
        P_DE:    {d_d, e_d} = rf.addr_data;
        P_HL:    {h_d, l_d} = rf.addr_data;
        P_SP:    sp_d = rf.addr_data;
        P_PC:    pc_d = rf.addr_data;
        P_WZ:    {w_d, z_d} = rf.addr_data;
        default: ;
      endcase
    end
    pc_fix_d = (rf.wr_en && rf.wr_sel == R_PCL) ? fix_of(rf.PC_inc_h, rf.PC_dec_h) : FIX_NONE;
    sp_fix_d = (rf.wr_en && rf.wr_sel == R_SPL) ? fix_of(rf.SP_inc_h, rf.SP_dec_h) : FIX_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= 8'h00; b_q <= 8'h00; c_q <= 8'h00; d_q <= 8'h00; e_q <= 8'h00;
      h_q <= 8'h00; l_q <= 8'h00; w_q <= 8'h00; z_q <= 8'h00; f_q <= 4'h0;
      sp_q <= 16'hFFFE;
      pc_q <= 16'h0000;
      pc_fix_q <= FIX_NONE;
      sp_fix_q <= FIX_NONE;
    end else begin
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; e_q <= e_d;
      h_q <= h_d; l_q <= l_d; w_q <= w_d; z_q <= z_d; f_q <= f_d;
      sp_q <= sp_d;
      pc_q <= pc_d;
      pc_fix_q <= pc_fix_d;
      sp_fix_q <= sp_fix_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) rd_view[i] = 8'hFF;
    rd_view[R_B]   = b_q;
    rd_view[R_C]   = c_q;
    rd_view[R_D]   = d_q;
    rd_view[R_E]   = e_q;
    rd_view[R_H]   = h_q;
    rd_view[R_L]   = l_q;
    rd_view[R_F]   = {f_q, 4'b0000};
    rd_view[R_A]   = a_q;
    rd_view[R_SPH] = sp_q[15:8];
    rd_view[R_SPL] = sp_q[7:0];
    rd_view[R_PCH] = pc_q[15:8];
    rd_view[R_PCL] = pc_q[7:0];
    rd_view[R_W]   = w_q;
    rd_view[R_Z]   = z_q;
  end

  assign rf.rd_A        = rd_view[rf.rd_sel_A];
  assign rf.rd_B        = rd_view[rf.rd_sel_B];
  assign rf.curr_flags  = f_q;
  assign rf.pc          = pc_q;
  assign rf.sp          = sp_q;
  assign rf.hl          = {h_q, l_q};
  assign rf.wz          = {w_q, z_q};
  assign rf.fix_pending = (pc_fix_q != FIX_NONE) || (sp_fix_q != FIX_NONE);
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a table of per-cycle vectors with hand-computed
// post-edge expectations, plus reset sequences around a pending fixup.
module tb_register_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_file_if rf ();
  register_file dut (.clk(clk), .rst(rst), .rf(rf));

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        flags_we;
    logic [3:0]  next_flags;
    logic        addr_we;
    logic [2:0]  addr_sel;
    logic [15:0] addr_data;
    logic [3:0]  adj;      // {PC_inc_h, PC_dec_h, SP_inc_h, SP_dec_h}
    logic        pc_inc;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic [15:0] e_pc;
    logic [15:0] e_sp;
    logic [15:0] e_hl;
    logic [15:0] e_wz;
    logic [3:0]  e_fl;
    logic        e_fp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rf.wr_en = 1'b0; rf.wr_sel = 4'd0; rf.wr_data = 8'h00;
    rf.flags_we = 1'b0; rf.next_flags = 4'h0;
    rf.addr_we = 1'b0; rf.addr_sel = 3'd0; rf.addr_data = 16'h0000;
    rf.PC_inc_h = 1'b0; rf.PC_dec_h = 1'b0; rf.SP_inc_h = 1'b0; rf.SP_dec_h = 1'b0;
    rf.pc_inc = 1'b0; rf.rd_sel_A = 4'd7; rf.rd_sel_B = 4'd6;
  endtask

  task automatic drive(input vec_t v);
    rf.wr_en = v.wr_en; rf.wr_sel = v.wr_sel; rf.wr_data = v.wr_data;
    rf.flags_we = v.flags_we; rf.next_flags = v.next_flags;
    rf.addr_we = v.addr_we; rf.addr_sel = v.addr_sel; rf.addr_data = v.addr_data;
    {rf.PC_inc_h, rf.PC_dec_h, rf.SP_inc_h, rf.SP_dec_h} = v.adj;
    rf.pc_inc = v.pc_inc; rf.rd_sel_A = v.sel_a; rf.rd_sel_B = v.sel_b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, rf.pc, 16'h0000);
    chk({tag, "_sp"}, rf.sp, 16'hFFFE);
    chk({tag, "_flags"}, {12'h0, rf.curr_flags}, 16'h0000);
    chk({tag, "_fix_pending"}, {15'h0, rf.fix_pending}, 16'h0000);
    chk({tag, "_rd_A"}, {8'h0, rf.rd_A}, 16'h0000);
    chk({tag, "_hl"}, rf.hl, 16'h0000);
  endtask

  task automatic add(input logic we, input logic [3:0] ws, input logic [7:0] wd,
                     input logic fwe, input logic [3:0] nf,
                     input logic awe, input logic [2:0] as, input logic [15:0] ad,
                     input logic [3:0] adj, input logic inc,
                     input logic [3:0] sa, input logic [3:0] sb,
                     input logic [7:0] ea, input logic [7:0] eb,
                     input logic [15:0] epc, input logic [15:0] esp,
                     input logic [15:0] ehl, input logic [15:0] ewz,
                     input logic [3:0] efl, input logic efp);
    vec_t v;
    v.wr_en = we; v.wr_sel = ws; v.wr_data = wd; v.flags_we = fwe; v.next_flags = nf;
    v.addr_we = awe; v.addr_sel = as; v.addr_data = ad; v.adj = adj; v.pc_inc = inc;
    v.sel_a = sa; v.sel_b = sb; v.e_a = ea; v.e_b = eb; v.e_pc = epc; v.e_sp = esp;
    v.e_hl = ehl; v.e_wz = ewz; v.e_fl = efl; v.e_fp = efp;
    vecs.push_back(v);
  endtask

  initial begin
    // we ws  wd    fwe nf  awe as ad        adj   inc sa  sb   ea     eb     pc        sp        hl        wz        fl   fp
    add(1, 0,  8'h11, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 0,  1,  8'h11, 8'h00, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 4'h0, 0);
    add(1, 1,  8'h22, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 1,  0,  8'h22, 8'h11, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 4'h0, 0);
    add(1, 4,  8'h12, 0, 0, 1, 2, 16'hBEEF, 4'b0000, 0, 4,  5,  8'hBE, 8'hEF, 16'h0000, 16'hFFFE, 16'hBEEF, 16'h0000, 4'h0, 0);
    add(1, 6,  8'hFF, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 6,  7,  8'hF0, 8'h00, 16'h0000, 16'hFFFE, 16'hBEEF, 16'h0000, 4'hF, 0);
    add(1, 6,  8'hFF, 1, 5, 0, 0, 16'h0000, 4'b0000, 0, 6,  7,  8'h50, 8'h00, 16'h0000, 16'hFFFE, 16'hBEEF, 16'h0000, 4'h5, 0);
    add(1, 14, 8'h77, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 14, 15, 8'hFF, 8'hFF, 16'h0000, 16'hFFFE, 16'hBEEF, 16'h0000, 4'h5, 0);
    add(0, 0,  8'h00, 0, 0, 1, 5, 16'h1234, 4'b0000, 0, 12, 13, 8'h12, 8'h34, 16'h0000, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    // JR forward: 12F0, PCl=10 with carry -> 1310 one cycle later
    add(0, 0,  8'h00, 0, 0, 1, 4, 16'h12F0, 4'b0000, 0, 10, 11, 8'h12, 8'hF0, 16'h12F0, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(1, 11, 8'h10, 0, 0, 0, 0, 16'h0000, 4'b1000, 0, 10, 11, 8'h12, 8'h10, 16'h1210, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 1);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 10, 11, 8'h13, 8'h10, 16'h1310, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    // JR backward, then the same from 0005 so PCh wraps
    add(0, 0,  8'h00, 0, 0, 1, 4, 16'h1205, 4'b0000, 0, 10, 11, 8'h12, 8'h05, 16'h1205, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(1, 11, 8'hFB, 0, 0, 0, 0, 16'h0000, 4'b0100, 0, 10, 11, 8'h12, 8'hFB, 16'h12FB, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 1);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 10, 11, 8'h11, 8'hFB, 16'h11FB, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(0, 0,  8'h00, 0, 0, 1, 4, 16'h0005, 4'b0000, 0, 10, 11, 8'h00, 8'h05, 16'h0005, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(1, 11, 8'hFB, 0, 0, 0, 0, 16'h0000, 4'b0100, 0, 10, 11, 8'h00, 8'hFB, 16'h00FB, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 1);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 10, 11, 8'hFF, 8'hFB, 16'hFFFB, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    // Fixup cancelled by addr_we PC in the apply cycle
    add(0, 0,  8'h00, 0, 0, 1, 4, 16'h12F0, 4'b0000, 0, 10, 11, 8'h12, 8'hF0, 16'h12F0, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(1, 11, 8'h10, 0, 0, 0, 0, 16'h0000, 4'b1000, 0, 10, 11, 8'h12, 8'h10, 16'h1210, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 1);
    add(0, 0,  8'h00, 0, 0, 1, 4, 16'h4000, 4'b0000, 0, 10, 11, 8'h40, 8'h00, 16'h4000, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 10, 11, 8'h40, 8'h00, 16'h4000, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    // pc_inc merged with the fixup: 12FF -> 13FF -> 1400
    add(0, 0,  8'h00, 0, 0, 1, 4, 16'h1200, 4'b0000, 0, 10, 11, 8'h12, 8'h00, 16'h1200, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(1, 11, 8'hFF, 0, 0, 0, 0, 16'h0000, 4'b1000, 0, 10, 11, 8'h12, 8'hFF, 16'h12FF, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 1);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 1, 10, 11, 8'h14, 8'h00, 16'h1400, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(0, 0,  8'h00, 0, 0, 1, 4, 16'hFFFF, 4'b0000, 0, 10, 11, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 1, 10, 11, 8'h00, 8'h00, 16'h0000, 16'hFFFE, 16'hBEEF, 16'h1234, 4'h5, 0);
    // SP fixup with SPh wrap, then an SP fixup cancelled by an SPh write
    add(1, 9,  8'h02, 0, 0, 0, 0, 16'h0000, 4'b0010, 0, 8,  9,  8'hFF, 8'h02, 16'h0000, 16'hFF02, 16'hBEEF, 16'h1234, 4'h5, 1);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 8,  9,  8'h00, 8'h02, 16'h0000, 16'h0002, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(1, 9,  8'h80, 0, 0, 0, 0, 16'h0000, 4'b0001, 0, 8,  9,  8'h00, 8'h80, 16'h0000, 16'h0080, 16'hBEEF, 16'h1234, 4'h5, 1);
    add(1, 8,  8'hAA, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 8,  9,  8'hAA, 8'h80, 16'h0000, 16'hAA80, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 0, 8,  9,  8'hAA, 8'h80, 16'h0000, 16'hAA80, 16'hBEEF, 16'h1234, 4'h5, 0);
    // Both inc and dec: no fixup captured
    add(1, 11, 8'h55, 0, 0, 0, 0, 16'h0000, 4'b1100, 0, 10, 11, 8'h00, 8'h55, 16'h0055, 16'hAA80, 16'hBEEF, 16'h1234, 4'h5, 0);
    // pc_inc ignored under explicit PCh write, then a plain increment
    add(1, 10, 8'h77, 0, 0, 0, 0, 16'h0000, 4'b0000, 1, 10, 11, 8'h77, 8'h55, 16'h7755, 16'hAA80, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 1, 10, 11, 8'h77, 8'h56, 16'h7756, 16'hAA80, 16'hBEEF, 16'h1234, 4'h5, 0);
    add(0, 0,  8'h00, 1, 4'hA, 0, 0, 16'h0000, 4'b0000, 0, 6, 7, 8'hA0, 8'h00, 16'h7756, 16'hAA80, 16'hBEEF, 16'h1234, 4'hA, 0);
    // Adjust request without a PCl write schedules nothing
    add(0, 0,  8'h00, 0, 0, 0, 0, 16'h0000, 4'b1000, 1, 10, 11, 8'h77, 8'h57, 16'h7757, 16'hAA80, 16'hBEEF, 16'h1234, 4'hA, 0);
    add(1, 11, 8'h00, 0, 0, 0, 0, 16'h0000, 4'b0000, 1, 10, 11, 8'h77, 8'h00, 16'h7700, 16'hAA80, 16'hBEEF, 16'h1234, 4'hA, 0);
    add(0, 0,  8'h00, 0, 0, 1, 6, 16'hDEAD, 4'b0000, 0, 2,  3,  8'h00, 8'h00, 16'h7700, 16'hAA80, 16'hBEEF, 16'h1234, 4'hA, 0);

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset_initial");

    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d_rd_A", i), {8'h0, rf.rd_A}, {8'h0, vecs[i].e_a});
      chk($sformatf("v%0d_rd_B", i), {8'h0, rf.rd_B}, {8'h0, vecs[i].e_b});
      chk($sformatf("v%0d_pc", i), rf.pc, vecs[i].e_pc);
      chk($sformatf("v%0d_sp", i), rf.sp, vecs[i].e_sp);
      chk($sformatf("v%0d_hl", i), rf.hl, vecs[i].e_hl);
      chk($sformatf("v%0d_wz", i), rf.wz, vecs[i].e_wz);
      chk($sformatf("v%0d_flags", i), {12'h0, rf.curr_flags}, {12'h0, vecs[i].e_fl});
      chk($sformatf("v%0d_fix_pending", i), {15'h0, rf.fix_pending}, {15'h0, vecs[i].e_fp});
    end

    // Reset in the apply cycle discards the pending fixup
    idle_inputs();
    rf.wr_en = 1'b1; rf.wr_sel = 4'd11; rf.wr_data = 8'h40; rf.PC_inc_h = 1'b1;
    tick();
    chk("midfix_pending", {15'h0, rf.fix_pending}, 16'h0001);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("reset_midfix");
    tick();
    chk("midfix_no_late_apply", rf.pc, 16'h0000);

    // Random state then reset
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      rf.wr_en = 1'b1;
      rf.wr_sel = 4'($urandom_range(0, 13));
      rf.wr_data = 8'($urandom_range(1, 255));
      rf.flags_we = 1'($urandom_range(0, 1));
      rf.next_flags = 4'($urandom_range(1, 15));
      rf.addr_we = 1'($urandom_range(0, 1));
      rf.addr_sel = 3'($urandom_range(0, 5));
      rf.addr_data = 16'($urandom_range(1, 65535));
      rf.SP_inc_h = 1'b1;
      tick();
    end
    idle_inputs();
    rf.wr_en = 1'b1; rf.wr_sel = 4'd9; rf.wr_data = 8'h12; rf.SP_dec_h = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check_reset_state("reset_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
